player_shot_ctrl: RTL and testbench
===================================

// Module: player_shot_ctrl
//
// PURPOSE
//   Sequences the single player missile: arms it on a fire press, moves it up
//   one step per move tick, and ends flight on a hit or at the top of the field.
//   It then holds an explosion and a reload cooldown before another shot is allowed.
//   Sits beside the player block and takes its position; feeds the renderer and collision logic.
//   Render-visible outputs are double-buffered and update only on frame.
//
// PARAMETERS
//   SHOT_STEP       4   pixels moved up per clk_move tick
//   SHOT_W          2   missile width, pixels (scaled)
//   SHOT_H          8   missile height, pixels (scaled)
//   SHOT_TOP        24  y at or above which the missile explodes (top-of-field miss)
//   EXPLODE_TICKS   8   clk_move ticks spent in EXPLODE
//   COOLDOWN_TICKS  4   clk_move ticks spent in COOLDOWN before re-arm
//
// PORTS
//   clk            in   1   system clock
//   rst_n          in   1   asynchronous reset, active-low
//   clk_move       in   1   1-cycle move strobe
//   frame          in   1   1-cycle start-of-blanking strobe
//   fire           in   1   debounced fire button, level
//   player_x       in   10  player sprite left x (frame-stable)
//   player_y       in   10  player sprite top y (frame-stable)
//   hit            in   1   1-cycle strobe from collision logic, missile struck a target
//   shot_x         out  10  missile left x, frame-latched
//   shot_y         out  10  missile top y, frame-latched
//   shot_active    out  1   missile drawable, frame-latched
//   shot_explode   out  1   explosion sprite drawable, frame-latched
//   shot_fired     out  1   1-cycle pulse on launch (sound trigger), not frame-latched
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, x/y internal and outputs = 0, all flags 0, fire_armed=1.
//   - Fire edge: launch needs fire=1 with fire_armed=1.
//     - Launching clears fire_armed.
//     - fire_armed is set again on any cycle with fire=0.
//     - Holding fire never auto-repeats.
//   - FSM (internal state updates on clk; events other than launch/hit advance only on clk_move):
//     - IDLE: fire launch -> FLIGHT same cycle.
//       - x = player_x + (SPRITE_WIDTH_SCALED-SHOT_W)/2, y = player_y - SHOT_H.
//       - shot_fired=1 for 1 cycle.
//     - FLIGHT:
//       - hit=1 -> EXPLODE. Highest priority; wins over a simultaneous clk_move.
//       - Otherwise on clk_move:
//         - y <= SHOT_TOP+SHOT_STEP -> EXPLODE with y=SHOT_TOP.
//         - Else y -= SHOT_STEP.
//     - EXPLODE: x/y frozen; count EXPLODE_TICKS clk_move ticks -> COOLDOWN.
//     - COOLDOWN: count COOLDOWN_TICKS ticks -> IDLE. fire ignored, but fire_armed still tracks fire=0.
//   - hit outside FLIGHT is ignored.
//   - The tick counter is cleared on every state entry and is 4 bits wide.
//     - Parameters > 15 are illegal; fail with an elaboration $error.
//   - All y arithmetic is 10-bit unsigned; the SHOT_TOP clamp prevents wrap below 0.
//   - Frame latch: on frame=1, outputs take the internal values of that same cycle (pre-update).
//     - shot_active = (state==FLIGHT), shot_explode = (state==EXPLODE).
//     - Between frames, outputs hold.
//   - frame and clk_move coincident: latch captures the old value; the move still applies.
//   - Launch latency: fire edge to shot_active visible = next frame strobe.
//
// STRUCTURE
//   - RES_H, SPRITE_WIDTH_SCALED and the SHOT_* defaults go in util/constants.v.
//   - State encodings are local params: IDLE=0, FLIGHT=1, EXPLODE=2, COOLDOWN=3.
//   - One natural sub-module, frame_latch: parameterised-width register, load on frame, async clear.
//     - Reusable for the player and invader outputs.
//
// TESTING
//   1. Reset mid-FLIGHT (rst_n low 1 cycle) -> all outputs 0, state IDLE, with no clk edge needed.
//   2. Launch at player_x=100, player_y=440, then frame:
//      -> shot_x=103 (SPRITE_WIDTH_SCALED=8), shot_y=432, shot_active=1.
//      -> shot_fired pulses exactly once.
//   3. Fire held through 200 clk_move ticks -> exactly one launch; release, press -> second launch after cooldown.
//   4. No hit from y=432:
//      -> after 102 ticks y=24 and EXPLODE, with no underflow.
//      -> after 8 more ticks COOLDOWN; after 4 more IDLE.
//   5. hit and clk_move same cycle at y=200 -> EXPLODE, y stays 200; hit during COOLDOWN -> no effect.
//   6. frame and clk_move same cycle -> shot_y shows the pre-move value; the next frame shows it minus 4.

Source files
------------

// File: rtl/player_shot_ctrl_pkg.sv
// rtl/player_shot_ctrl_pkg.sv - shared constants and state type for the player missile
package player_shot_ctrl_pkg;

  localparam int RES_H               = 480;
  localparam int SPRITE_WIDTH_SCALED = 8;

  localparam int SHOT_STEP_DEF      = 4;
  localparam int SHOT_W_DEF         = 2;
  localparam int SHOT_H_DEF         = 8;
  localparam int SHOT_TOP_DEF       = 24;
  localparam int EXPLODE_TICKS_DEF  = 8;
  localparam int COOLDOWN_TICKS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLIGHT   = 2'd1,
    ST_EXPLODE  = 2'd2,
    ST_COOLDOWN = 2'd3
  } shot_state_t;

  // Missile is centred horizontally on the player sprite.
  function automatic logic [9:0] shot_launch_x(input logic [9:0] px, input int shot_w);
    return px + 10'((SPRITE_WIDTH_SCALED - shot_w) / 2);
  endfunction

endpackage

// File: rtl/player_shot_ctrl_frame_latch.sv
// rtl/player_shot_ctrl_frame_latch.sv - render-side register, loads on the frame strobe
module player_shot_ctrl_frame_latch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/player_shot_ctrl.sv
// rtl/player_shot_ctrl.sv - player missile sequencer: launch, flight, explosion, reload
module player_shot_ctrl
  import player_shot_ctrl_pkg::*;
#(
  parameter int SHOT_STEP      = SHOT_STEP_DEF,
  parameter int SHOT_W         = SHOT_W_DEF,
  parameter int SHOT_H         = SHOT_H_DEF,
  parameter int SHOT_TOP       = SHOT_TOP_DEF,
  parameter int EXPLODE_TICKS  = EXPLODE_TICKS_DEF,
  parameter int COOLDOWN_TICKS = COOLDOWN_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_move,
  input  logic       frame,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       hit,
  output logic [9:0] shot_x,
  output logic [9:0] shot_y,
  output logic       shot_active,
  output logic       shot_explode,
  output logic       shot_fired
);

  if (EXPLODE_TICKS < 1 || EXPLODE_TICKS > 15) begin : g_bad_explode
    $error("EXPLODE_TICKS must be within 1..15");
  end
  if (COOLDOWN_TICKS < 1 || COOLDOWN_TICKS > 15) begin : g_bad_cooldown
    $error("COOLDOWN_TICKS must be within 1..15");
  end
  if (SHOT_TOP + SHOT_STEP >= RES_H) begin : g_bad_top
    $error("SHOT_TOP + SHOT_STEP must lie inside the field");
  end

  localparam logic [9:0] STEP      = 10'(SHOT_STEP);
  localparam logic [9:0] HEIGHT    = 10'(SHOT_H);
  localparam logic [9:0] TOP       = 10'(SHOT_TOP);
  localparam logic [9:0] TOP_LIMIT = 10'(SHOT_TOP + SHOT_STEP);
  localparam logic [3:0] EXP_LAST  = 4'(EXPLODE_TICKS - 1);
  localparam logic [3:0] CD_LAST   = 4'(COOLDOWN_TICKS - 1);

  shot_state_t state;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [3:0]  tick;
  logic        fire_armed;
  logic        launch;

  assign launch = (state == ST_IDLE) && fire && fire_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      tick       <= '0;
      fire_armed <= 1'b1;
      shot_fired <= 1'b0;
    end else begin
      shot_fired <= launch;
      // Re-arm only after a release so a held button never auto-repeats.
      if (launch) begin
        fire_armed <= 1'b0;
      end else if (!fire) begin
        fire_armed <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (launch) begin
            state <= ST_FLIGHT;
            x     <= shot_launch_x(player_x, SHOT_W);
            y     <= player_y - HEIGHT;
            tick  <= '0;
          end
        end
        ST_FLIGHT: begin
          if (hit) begin
            state <= ST_EXPLODE;
            tick  <= '0;
          end else if (clk_move) begin
            // Clamp at the top so the 10-bit y can never wrap.
            if (y <= TOP_LIMIT) begin
              y     <= TOP;
              state <= ST_EXPLODE;
              tick  <= '0;
            end else begin
              y <= y - STEP;
            end
          end
        end
        ST_EXPLODE: begin
          if (clk_move) begin
            if (tick == EXP_LAST) begin
              state <= ST_COOLDOWN;
              tick  <= '0;
            end else begin
              tick <= tick + 4'd1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (clk_move) begin
            if (tick == CD_LAST) begin
              state <= ST_IDLE;
              tick  <= '0;
            end else begin
              tick <= tick + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [21:0] latch_d;
  logic [21:0] latch_q;

  assign latch_d = {x, y, state == ST_FLIGHT, state == ST_EXPLODE};

  player_shot_ctrl_frame_latch #(
    .WIDTH(22)
  ) u_frame_latch (
    .clk  (clk),
    .rst_n(rst_n),
    .load (frame),
    .d    (latch_d),
    .q    (latch_q)
  );

  assign shot_x       = latch_q[21:12];
  assign shot_y       = latch_q[11:2];
  assign shot_active  = latch_q[1];
  assign shot_explode = latch_q[0];

endmodule

// File: tb/tb_player_shot_ctrl.sv
// tb/tb_player_shot_ctrl.sv - scoreboard bench for the player missile sequencer
module tb_player_shot_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_move;
  logic       frame;
  logic       fire;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       hit;
  logic [9:0] shot_x;
  logic [9:0] shot_y;
  logic       shot_active;
  logic       shot_explode;
  logic       shot_fired;

  player_shot_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_move    (clk_move),
    .frame       (frame),
    .fire        (fire),
    .player_x    (player_x),
    .player_y    (player_y),
    .hit         (hit),
    .shot_x      (shot_x),
    .shot_y      (shot_y),
    .shot_active (shot_active),
    .shot_explode(shot_explode),
    .shot_fired  (shot_fired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_launch = 0;

  logic [21:0] sb_q[$];

  int   m_state;
  int   m_x;
  int   m_y;
  int   m_tick;
  logic m_armed;
  logic exp_fired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_x     = 0;
    m_y     = 0;
    m_tick  = 0;
    m_armed = 1'b1;
    sb_q.delete();
  endtask

  // Reference behaviour of one clock cycle; frame snapshots use pre-update values.
  task automatic model_step(input logic mv, input logic frm, input logic f, input logic h);
    logic go;
    logic [21:0] e;
    if (frm) begin
      e = {10'(m_x), 10'(m_y), m_state == 1, m_state == 2};
      sb_q.push_back(e);
    end
    go = (m_state == 0) && f && m_armed;
    exp_fired = go;
    case (m_state)
      0: if (go) begin m_x = int'(player_x) + 3; m_y = int'(player_y) - 8; m_state = 1; m_tick = 0; end
      1: if (h) begin
           m_state = 2; m_tick = 0;
         end else if (mv) begin
           if (m_y <= 28) begin m_y = 24; m_state = 2; m_tick = 0; end
           else m_y = m_y - 4;
         end
      2: if (mv) begin m_tick++; if (m_tick == 8) begin m_state = 3; m_tick = 0; end end
      default: if (mv) begin m_tick++; if (m_tick == 4) begin m_state = 0; m_tick = 0; end end
    endcase
    if (go) m_armed = 1'b0;
    else if (!f) m_armed = 1'b1;
  endtask

  task automatic step(input logic mv, input logic frm, input logic h);
    logic [21:0] e;
    clk_move = mv;
    frame    = frm;
    hit      = h;
    model_step(mv, frm, fire, h);
    @(posedge clk);
    #1;
    check("shot_fired", shot_fired, exp_fired);
    if (shot_fired) n_launch++;
    if (frm) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_x", shot_x, e[21:12]);
        check("sb_y", shot_y, e[11:2]);
        check("sb_active", shot_active, e[1]);
        check("sb_explode", shot_explode, e[0]);
      end
    end
    clk_move = 1'b0;
    frame    = 1'b0;
    hit      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic show();
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, shot_x, 0);
    check({tag, "_y"}, shot_y, 0);
    check({tag, "_active"}, shot_active, 0);
    check({tag, "_explode"}, shot_explode, 0);
    check({tag, "_fired"}, shot_fired, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n    = 1'b0;
    clk_move = 1'b0;
    frame    = 1'b0;
    fire     = 1'b0;
    hit      = 1'b0;
    player_x = 10'd100;
    player_y = 10'd440;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Launch, one pulse, frame makes it visible
    fire = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("launch_pulse", shot_fired, 1);
    check("not_visible_yet", shot_active, 0);
    fire = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    show();
    check("launch_x", shot_x, 103);
    check("launch_y", shot_y, 432);
    check("launch_active", shot_active, 1);
    check("launch_count", n_launch, 1);

    // Full flight to the top of the field, explosion, cooldown
    ticks(101);
    show();
    check("pre_top_y", shot_y, 28);
    ticks(1);
    show();
    check("top_y", shot_y, 24);
    check("top_explode", shot_explode, 1);
    check("top_active", shot_active, 0);
    ticks(7);
    show();
    check("explode_7", shot_explode, 1);
    ticks(1);
    show();
    check("cooldown_explode", shot_explode, 0);
    check("cooldown_y", shot_y, 24);
    step(1'b0, 1'b0, 1'b1);
    ticks(3);
    fire = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("cooldown_no_fire", shot_fired, 0);
    fire = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    ticks(1);

    // Frame coincident with move shows the pre-move value
    player_y = 10'd300;
    fire = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("relaunch_pulse", shot_fired, 1);
    fire = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    ticks(2);
    step(1'b1, 1'b1, 1'b0);
    check("frame_move_old", shot_y, 284);
    show();
    check("frame_move_new", shot_y, 280);

    // Hit wins over a simultaneous move; hit in cooldown is ignored
    ticks(20);
    step(1'b1, 1'b0, 1'b1);
    show();
    check("hit_y", shot_y, 200);
    check("hit_explode", shot_explode, 1);
    ticks(8);
    step(1'b1, 1'b0, 1'b1);
    show();
    check("cd_hit_explode", shot_explode, 0);
    check("cd_hit_active", shot_active, 0);
    ticks(2);
    fire = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("cd_hit_no_fire", shot_fired, 0);
    fire = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    ticks(1);

    // Held fire never repeats
    base = n_launch;
    fire = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, (i % 10) == 0, 1'b0);
    end
    check("held_one_launch", n_launch, base + 1);
    fire = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    fire = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("repress_launch", n_launch, base + 2);
    fire = 1'b0;

    // Asynchronous reset in the middle of a flight
    ticks(3);
    show();
    check("pre_reset_active", shot_active, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fire = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("post_reset_launch", shot_fired, 1);
    fire = 1'b0;
    show();
    check("post_reset_y", shot_y, 292);
    check("post_reset_active", shot_active, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
